// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counting interval timer, one-shot or periodic.
// Ports: clk, reset (sync, high); load/load_value, start, stop, periodic in;
//        count, tc (expiry pulse), busy (RUN/HOLD), done (DONE) out, all registered.
module countdown_timer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         start,
  input  logic         stop,
  input  logic         periodic,
  output logic [N-1:0] count,
  output logic         tc,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD,
    DONE
  } state_t;

  localparam logic [N-1:0] ZERO = '0;
  localparam logic [N-1:0] ONE  = ZERO + 1'b1;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [N-1:0] r_count;
  logic [N-1:0] w_count_nxt;
  logic [N-1:0] r_reload;
  logic [N-1:0] w_reload_nxt;
  logic         r_periodic;
  logic         w_periodic_nxt;
  logic         r_tc;
  logic         w_tc_nxt;
  logic         r_busy;
  logic         w_busy_nxt;
  logic         r_done;
  logic         w_done_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_count    <= ZERO;
      r_reload   <= ZERO;
      r_periodic <= 1'b0;
      r_tc       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_reload   <= w_reload_nxt;
      r_periodic <= w_periodic_nxt;
      r_tc       <= w_tc_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // load > stop > start; only the winning input is acted on.
  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_reload_nxt   = r_reload;
    w_periodic_nxt = r_periodic;
    w_tc_nxt       = 1'b0;
    if (load) begin
      w_count_nxt  = load_value;
      w_reload_nxt = load_value;
      // a zero interval cannot run, so an active timer drops to IDLE silently
      if (r_state == IDLE || r_state == DONE || load_value == ZERO)
        w_state_nxt = IDLE;
    end else if (stop) begin
      if (r_state == RUN)
        w_state_nxt = HOLD;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start && r_count != ZERO) begin
            w_state_nxt    = RUN;
            w_periodic_nxt = periodic;
          end
        end
        RUN: begin
          if (r_count != ONE) begin
            w_count_nxt = r_count - ONE;
          end else begin
            w_tc_nxt = 1'b1;
            if (r_periodic) begin
              w_count_nxt = r_reload;
            end else begin
              w_count_nxt = ZERO;
              w_state_nxt = DONE;
            end
          end
        end
        HOLD: begin
          if (start)
            w_state_nxt = RUN;
        end
        DONE: begin
          if (start) begin
            w_state_nxt    = RUN;
            w_count_nxt    = r_reload;
            w_periodic_nxt = periodic;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // busy/done are registered decodes of the next state.
  always_comb begin
    w_busy_nxt = (w_state_nxt == RUN) || (w_state_nxt == HOLD);
    w_done_nxt = (w_state_nxt == DONE);
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed stimulus, behavioural model, per-cycle compare
// plus hand-computed literal checks.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_value = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       periodic = 1'b0;
  logic [3:0] count;
  logic       tc;
  logic       busy;
  logic       done;

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  countdown_timer #(.N(4)) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .load_value(load_value),
    .start(start),
    .stop(stop),
    .periodic(periodic),
    .count(count),
    .tc(tc),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Model: a timer is either idle, counting, paused or finished.
  int m_left = 0;
  int m_interval = 0;
  bit m_auto = 0;
  bit m_counting = 0;
  bit m_paused = 0;
  bit m_finished = 0;
  bit m_tc = 0;

  always @(posedge clk) begin
    m_tc = 0;
    if (reset) begin
      m_left = 0; m_interval = 0; m_auto = 0;
      m_counting = 0; m_paused = 0; m_finished = 0;
    end else if (load) begin
      m_left = load_value;
      m_interval = load_value;
      if (!(m_counting || m_paused) || load_value == 0) begin
        m_counting = 0; m_paused = 0; m_finished = 0;
      end
    end else if (stop) begin
      if (m_counting) begin
        m_counting = 0; m_paused = 1;
      end
    end else if (m_counting) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_tc = 1;
        if (m_auto) m_left = m_interval;
        else begin
          m_counting = 0; m_finished = 1;
        end
      end
    end else if (start) begin
      if (m_paused) begin
        m_paused = 0; m_counting = 1;
      end else if (m_finished) begin
        m_finished = 0; m_counting = 1;
        m_left = m_interval; m_auto = periodic;
      end else if (m_left != 0) begin
        m_counting = 1; m_auto = periodic;
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model.count", count, m_left);
      chk("model.tc", tc, m_tc);
      chk("model.busy", busy, m_counting || m_paused);
      chk("model.done", done, m_finished);
    end
  end

  // Apply inputs for one edge, return at the following negedge.
  task automatic drv(input bit rs, input bit ld, input int lv,
                     input bit st, input bit sp, input bit per);
    reset = rs; load = ld; load_value = 4'(lv);
    start = st; stop = sp; periodic = per;
    @(negedge clk);
    reset = 0; load = 0; start = 0; stop = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    drv(1, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    cmp_en = 1'b1;
    chk("rst.count", count, 0);
    chk("rst.tc", tc, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);

    drv(0, 0, 0, 1, 0, 0);
    chk("start0.busy", busy, 0);

    // one-shot 5
    drv(0, 1, 5, 0, 0, 0);
    drv(0, 0, 0, 1, 0, 0);
    chk("os.first", count, 5);
    chk("os.busy", busy, 1);
    for (int i = 4; i >= 1; i--) begin
      idle(1);
      chk("os.count", count, i);
      chk("os.tc0", tc, 0);
    end
    idle(1);
    chk("os.end", count, 0);
    chk("os.tc", tc, 1);
    chk("os.done", done, 1);
    chk("os.busy_off", busy, 0);
    idle(2);
    chk("os.hold", count, 0);
    chk("os.tc_once", tc, 0);

    // periodic 3
    drv(0, 1, 3, 0, 0, 0);
    drv(0, 0, 0, 1, 0, 1);
    chk("per.first", count, 3);
    for (int i = 1; i <= 10; i++) begin
      idle(1);
      chk("per.count", count, (i % 3 == 0) ? 3 : 3 - (i % 3));
      chk("per.tc", tc, (i % 3 == 0) ? 1 : 0);
      chk("per.busy", busy, 1);
    end

    // load 0 while running
    drv(0, 1, 0, 0, 0, 0);
    chk("ld0.busy", busy, 0);
    chk("ld0.tc", tc, 0);

    // pause / resume, one-shot 6
    drv(0, 1, 6, 0, 0, 0);
    drv(0, 0, 0, 1, 0, 0);
    idle(2);
    chk("pause.pre", count, 4);
    drv(0, 0, 0, 0, 1, 0);
    idle(2);
    chk("pause.held", count, 4);
    chk("pause.busy", busy, 1);
    drv(0, 0, 0, 1, 0, 0);
    chk("pause.resume", count, 4);
    idle(3);
    chk("pause.tc0", tc, 0);
    idle(1);
    chk("pause.tc", tc, 1);

    // load + start collide, then load 9 at count 1
    drv(0, 1, 7, 1, 0, 0);
    chk("col.idle", busy, 0);
    chk("col.count", count, 7);
    drv(0, 0, 0, 1, 0, 0);
    idle(6);
    chk("col.one", count, 1);
    drv(0, 1, 9, 0, 0, 0);
    chk("col.nine", count, 9);
    chk("col.notc", tc, 0);
    idle(1);
    chk("col.eight", count, 8);

    // L=1 one-shot, then periodic
    drv(0, 1, 0, 0, 0, 0);
    drv(0, 1, 1, 0, 0, 0);
    drv(0, 0, 0, 1, 0, 0);
    idle(1);
    chk("l1.tc", tc, 1);
    chk("l1.done", done, 1);
    drv(0, 1, 1, 0, 0, 0);
    drv(0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("l1p.tc", tc, 1);
      chk("l1p.count", count, 1);
    end

    // full range 15
    drv(0, 1, 0, 0, 0, 0);
    drv(0, 1, 15, 0, 0, 0);
    drv(0, 0, 0, 1, 0, 0);
    chk("l15.first", count, 15);
    idle(14);
    chk("l15.one", count, 1);
    chk("l15.tc0", tc, 0);
    idle(1);
    chk("l15.tc", tc, 1);
    chk("l15.zero", count, 0);
    drv(0, 0, 0, 1, 0, 0);
    chk("restart.count", count, 15);
    chk("restart.busy", busy, 1);

    // stop at count 1
    drv(0, 1, 0, 0, 0, 0);
    drv(0, 1, 2, 0, 0, 0);
    drv(0, 0, 0, 1, 0, 0);
    idle(1);
    drv(0, 0, 0, 0, 1, 0);
    chk("st1.count", count, 1);
    chk("st1.notc", tc, 0);
    drv(0, 0, 0, 1, 0, 0);
    chk("st1.resume_tc", tc, 0);
    idle(1);
    chk("st1.tc", tc, 1);

    // reset mid-run
    drv(0, 1, 4, 0, 0, 0);
    drv(0, 0, 0, 1, 0, 0);
    idle(2);
    chk("rs.pre", count, 2);
    drv(1, 0, 0, 0, 0, 0);
    chk("rs.count", count, 0);
    chk("rs.busy", busy, 0);
    chk("rs.done", done, 0);
    drv(0, 0, 0, 1, 0, 0);
    chk("rs.ignored", busy, 0);
    idle(2);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
